// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_ctrl_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   // INIT clears the register file, RUN arbitrates requester writes.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester bus and register-file write port of the write arbiter.
//
// Handshake: each requester raises req_valid[i] with req_addr/req_data
// slice i and holds all three stable until req_ready[i] is seen high.
// A write transfers on a rising clk edge where req_valid[i] and
// req_ready[i] are both high; req_ready is one-hot or zero.
interface regfile_write_arbiter_if #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W,
   parameter int DATA_W = regfile_ctrl_pkg::DATA_W
);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic                   rf_we;
   logic [ADDR_W-1:0]      rf_waddr;
   logic [DATA_W-1:0]      rf_wdata;
   logic [1:0]             gnt_id;
   logic                   init_done;

   // Requester side (also the register-file observer)
   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, rf_we, rf_waddr, rf_wdata, gnt_id, init_done
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, rf_we, rf_waddr, rf_wdata, gnt_id, init_done
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above
// ptr_i, wrapping at NREQ. Produces a one-hot grant and its index.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [1:0]      ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [1:0]      win_o,
   output logic            any_o
);

   // Scan from the pointer upward; the first hit wins
   always_comb begin
      int idx;
      idx   = 0;
      gnt_o = '0;
      win_o = '0;
      any_o = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         idx = int'(ptr_i) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any_o && req_i[idx]) begin
            any_o      = 1'b1;
            gnt_o[idx] = 1'b1;
            win_o      = 2'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: clears all registers after reset (INIT),
// then grants one requester write per cycle by round-robin (RUN).
// Writes reach the register file one cycle after their handshake.
// Optional macro REGFILE_WR_ZERO_FILTER_EN: RUN writes to address 0 are
// accepted but not issued to the register file (INIT still clears it).
// NREQ legal range is 2..4 (gnt_id is 2 bits wide).
module regfile_write_arbiter #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W,
   parameter int DATA_W = regfile_ctrl_pkg::DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   regfile_write_arbiter_if.slave   bus,
   output regfile_ctrl_pkg::state_e state_o
);

   import regfile_ctrl_pkg::*;

   // One extra bit so the counter can reach NUM_REGS and mark the end
   localparam int CNT_W = $clog2(NUM_REGS) + 1;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [1:0]         ptr_q;
   logic [1:0]         ptr_d;
   logic               rf_we_q;
   logic [ADDR_W-1:0]  rf_waddr_q;
   logic [DATA_W-1:0]  rf_wdata_q;
   logic [1:0]         gnt_id_q;
   logic               init_done_q;

   logic [NREQ-1:0]    gnt;
   logic [1:0]         win;
   logic               any;
   logic [NREQ-1:0]    req_ready;
   logic               xfer;
   logic               issue;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_data;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req_i (bus.req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .win_o (win),
      .any_o (any)
   );

   // Ready is offered only in RUN, directly from the arbiter grant
   always_comb begin
      req_ready = '0;
      if (state_q == RUN) req_ready = gnt;
   end

   assign xfer = (state_q == RUN) && any;

   // Select the winning requester's address and data slice
   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            win_data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef REGFILE_WR_ZERO_FILTER_EN
   assign issue = xfer && (win_addr != '0);
`else
   assign issue = xfer;
`endif

   // Pointer moves to the requester just after the winner
   always_comb begin
      ptr_d = win + 2'd1;
      if (int'(win) == NREQ - 1) ptr_d = '0;
   end

   // FSM, clear counter, pointer and registered write port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         ptr_q       <= '0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         gnt_id_q    <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               if (cnt_q == CNT_W'(NUM_REGS)) begin
                  state_q     <= RUN;
                  init_done_q <= 1'b1;
                  rf_we_q     <= 1'b0;
               end else begin
                  rf_we_q    <= 1'b1;
                  rf_waddr_q <= ADDR_W'(cnt_q);
                  rf_wdata_q <= '0;
                  gnt_id_q   <= '0;
                  cnt_q      <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               rf_we_q <= 1'b0;
               if (xfer) ptr_q <= ptr_d;
               if (issue) begin
                  rf_we_q    <= 1'b1;
                  rf_waddr_q <= win_addr;
                  rf_wdata_q <= win_data;
                  gnt_id_q   <= win;
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.init_done = init_done_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: INIT sequence checks, directed
// scenarios and random traffic against a round-robin reference model.
module tb_regfile_write_arbiter;
   import regfile_ctrl_pkg::*;

   localparam int NREQ = 2;
   localparam int AW   = ADDR_W;
   localparam int DW   = DATA_W;
   localparam int EW   = 2 + AW + DW;
`ifdef REGFILE_WR_ZERO_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   logic   clk = 1'b0;
   logic   reset = 1'b0;
   state_e state_o;

   regfile_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) intf ();

   regfile_write_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (intf),
      .state_o (state_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   int n_checks = 0;
   int n_errors = 0;
   logic [EW-1:0] exp_q[$];

   logic          v   [NREQ];
   logic [AW-1:0] a   [NREQ];
   logic [DW-1:0] d   [NREQ];
   logic          acc [NREQ];
   int  mptr      = 0;
   bit  model_en  = 1'b0;
   bit  mon_en    = 1'b0;
   int  mode      = 0;
   int  cnt1      = 0;
   bit  zero_sent = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         intf.req_valid[i]           = v[i];
         intf.req_addr[i*AW +: AW]   = a[i];
         intf.req_data[i*DW +: DW]   = d[i];
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NREQ; i++) begin
         v[i] = 1'b0; a[i] = '0; d[i] = '0; acc[i] = 1'b0;
      end
      apply();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) begin
            v[i]   = 1'b0;
            acc[i] = 1'b0;
         end
      end
      case (mode)
         1: if (!v[1] && cnt1 < 8) begin
               v[1] = 1'b1; a[1] = AW'(7); d[1] = DW'(32'h10 + cnt1); cnt1++;
            end
         2: begin
               if (!v[0]) begin v[0] = 1'b1; a[0] = AW'(3); d[0] = 32'hAAAA_0001; end
               if (!v[1]) begin v[1] = 1'b1; a[1] = AW'(4); d[1] = 32'hBBBB_0002; end
            end
         3: if (!zero_sent) begin
               v[0] = 1'b1; a[0] = '0; d[0] = 32'hDEAD_BEEF; zero_sent = 1'b1;
            end
         4: for (int i = 0; i < NREQ; i++) begin
               if (!v[i] && $urandom_range(0, 1) == 1) begin
                  v[i] = 1'b1;
                  a[i] = AW'($urandom_range(0, NUM_REGS - 1));
                  d[i] = DW'($urandom);
               end
            end
         default: ;
      endcase
      apply();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rf_we"},     64'(intf.rf_we),     64'd0);
      chk({tag, "_rf_waddr"},  64'(intf.rf_waddr),  64'd0);
      chk({tag, "_rf_wdata"},  64'(intf.rf_wdata),  64'd0);
      chk({tag, "_gnt_id"},    64'(intf.gnt_id),    64'd0);
      chk({tag, "_req_ready"}, 64'(intf.req_ready), 64'd0);
      chk({tag, "_init_done"}, 64'(intf.init_done), 64'd0);
      chk({tag, "_state"},     64'(state_o),        64'(INIT));
   endtask

   // Expect the clear sequence: one zero write per cycle, addresses ascending
   task automatic init_check(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         chk("init_we",        64'(intf.rf_we),     64'd1);
         chk("init_waddr",     64'(intf.rf_waddr),  64'(k));
         chk("init_wdata",     64'(intf.rf_wdata),  64'd0);
         chk("init_gnt_id",    64'(intf.gnt_id),    64'd0);
         chk("init_done_low",  64'(intf.init_done), 64'd0);
         chk("init_ready_low", 64'(intf.req_ready), 64'd0);
      end
   endtask

   // reference model: round-robin grant from the rules, expected writes queued
   always @(negedge clk) begin
      if (model_en) begin
         int w;
         int idx;
         logic [NREQ-1:0] er;
         w  = -1;
         er = '0;
         for (int off = 0; off < NREQ; off++) begin
            idx = (mptr + off) % NREQ;
            if (w < 0 && v[idx]) w = idx;
         end
         if (w >= 0) er[w] = 1'b1;
         chk("req_ready", 64'(intf.req_ready), 64'(er));
         if (w >= 0) begin
            acc[w] = 1'b1;
            if (!(FILTER && a[w] == '0)) exp_q.push_back({2'(w), a[w], d[w]});
            mptr = (w + 1) % NREQ;
         end
      end
   end

   // monitor: every register-file write must match the oldest expectation
   always @(negedge clk) begin
      if (mon_en) begin
         logic [EW-1:0] e;
         chk("init_done_high", 64'(intf.init_done), 64'd1);
         if (intf.rf_we) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_write: got addr %0h data %0h gnt %0d expected no write",
                        intf.rf_waddr, intf.rf_wdata, intf.gnt_id);
            end else begin
               e = exp_q.pop_front();
               chk("wr_gnt_id", 64'(intf.gnt_id),   64'(e[EW-1 -: 2]));
               chk("wr_addr",   64'(intf.rf_waddr), 64'(e[DW +: AW]));
               chk("wr_data",   64'(intf.rf_wdata), 64'(e[DW-1:0]));
            end
         end
      end
   end

   // main sequence
   initial begin
      clear_reqs();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");

      // reset arriving with the clear counter at 10
      @(negedge clk);
      reset = 1'b1;
      init_check(10);
      #2 reset = 1'b0;
      #1 check_reset_outputs("rst_init");
      repeat (2) @(posedge clk);

      // full clear with requester 0 waiting throughout
      #1;
      v[0] = 1'b1; a[0] = AW'(9); d[0] = 32'h1234_5678;
      apply();
      @(negedge clk);
      reset = 1'b1;
      init_check(NUM_REGS);
      #1;
      model_en = 1'b1;
      mon_en   = 1'b1;
      mode = 0; repeat (3) step();

      // lone requester 1, back-to-back
      mode = 1; cnt1 = 0; repeat (10) step();
      mode = 0; repeat (2) step();

      // both requesters contending
      mode = 2; repeat (8) step();
      mode = 0; repeat (3) step();

      // write to address 0
      mode = 3; zero_sent = 1'b0; step();
      mode = 0; repeat (3) step();

      // random traffic
      mode = 4; repeat (300) step();
      mode = 0; repeat (6) step();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      // reset in the middle of RUN traffic
      mode = 4; repeat (20) step();
      model_en = 1'b0;
      mon_en   = 1'b0;
      #1 reset = 1'b0;
      #1 check_reset_outputs("rst_run");
      exp_q.delete();
      mptr = 0;
      mode = 0;
      clear_reqs();
      @(negedge clk);
      reset = 1'b1;
      init_check(NUM_REGS);
      #1;
      model_en = 1'b1;
      mon_en   = 1'b1;
      mode = 4; repeat (50) step();
      mode = 0; repeat (6) step();
      chk("queue_empty_end", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of write requesters; the legal range SHALL be 2..4.
REQ-002 Parameter ADDR_W, default 5: register address width.
REQ-003 Parameter DATA_W, default 32: register data width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NREQ  per-requester write request.
REQ-007 req_ready  output  NREQ  per-requester accept; at most one bit SHALL be high in any cycle.
REQ-008 req_addr  input  NREQ*ADDR_W  packed target register addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-009 req_data  input  NREQ*DATA_W  packed write data; requester i occupies slice [i*DATA_W +: DATA_W].
REQ-010 rf_we  output  1  drives the register file RegWrite input.
REQ-011 rf_waddr  output  ADDR_W  drives the register file WriteRegister input.
REQ-012 rf_wdata  output  DATA_W  drives the register file WriteData input.
REQ-013 gnt_id  output  2  index of the requester whose write is on rf_* this cycle; 0 during INIT.
REQ-014 init_done  output  1  high once the register file clear sequence is complete.

Function
REQ-015 The FSM SHALL have two states: INIT and RUN.
REQ-016 INIT: the block SHALL write 0 to addresses 0..31 in ascending order, one per cycle, with rf_we=1; the first write SHALL appear in the first cycle after reset deasserts.
REQ-017 After the address-31 write, the FSM SHALL enter RUN on the next cycle and set init_done=1; init_done SHALL stay 1 until reset.
REQ-018 In INIT, req_ready SHALL be all-zero whatever req_valid is.
REQ-019 In RUN, each cycle the block SHALL grant one asserted req_valid by round-robin, searching from pointer ptr upward with wrap at NREQ.
REQ-020 req_ready[winner] SHALL be combinational in the cycle of the grant; a transfer SHALL occur only when valid and ready are both high.
REQ-021 After a transfer, ptr SHALL become (winner+1) mod NREQ; with no transfer, ptr SHALL hold.
REQ-022 rf_we, rf_waddr, rf_wdata and gnt_id SHALL be registered, so each accepted write appears exactly 1 cycle after its handshake.
REQ-023 With no transfer, rf_we SHALL be 0 and rf_waddr/rf_wdata SHALL hold their last values.
REQ-024 A requester SHALL hold valid, addr and data stable until ready; the block does not need to tolerate violations.
REQ-025 Sustained throughput SHALL be one write per cycle; a lone requester SHALL be granted every cycle.

Reset
REQ-026 Asserting reset SHALL immediately set rf_we=0, rf_waddr=0, rf_wdata=0, gnt_id=0, req_ready=0, init_done=0, ptr=0, init counter=0 and state=INIT, including when reset arrives mid-INIT or mid-RUN.

Configuration
REQ-027 With macro REGFILE_WR_ZERO_FILTER_EN defined, an accepted RUN write to address 0 SHALL complete its handshake and advance ptr, but SHALL leave rf_we=0 in the following cycle.
REQ-028 Without REGFILE_WR_ZERO_FILTER_EN, writes to address 0 SHALL be issued like any other address.
REQ-029 INIT SHALL write address 0 in both configurations.

Structure
REQ-030 Package regfile_ctrl_pkg SHALL hold ADDR_W, DATA_W, NUM_REGS=32 and the state enum {INIT, RUN}.
REQ-031 Round-robin selection SHALL live in sub-module rr_arbiter (inputs: request vector and ptr; outputs: one-hot grant and winner index); regfile_write_arbiter SHALL own the FSM, counter and output registers.

Verification
REQ-032 Release reset -> 32 consecutive cycles with rf_we=1, rf_waddr=0..31, rf_wdata=0; init_done=1 in the next cycle.
REQ-033 In RUN, hold req0 (addr 3, data 0xAAAA0001) and req1 (addr 4, data 0xBBBB0002) both valid -> grants alternate 0,1,0,1 starting with 0; rf_* follows each grant by 1 cycle with the matching gnt_id.
REQ-034 Only req1 valid for 8 cycles, with addr 7 and data incrementing from 0x10 -> 8 back-to-back writes 0x10..0x17 to address 7.
REQ-035 req0 writes addr 0, data 0xDEADBEEF -> ready=1 in both builds; next cycle rf_we=0 with the macro defined and rf_we=1, rf_wdata=0xDEADBEEF without it.
REQ-036 Assert reset when the INIT counter is 10 -> all outputs 0 immediately; after release, INIT restarts at address 0 and runs the full 32 cycles.
REQ-037 Hold req0 valid throughout INIT -> req_ready stays 0 during INIT; the request is accepted in the first RUN cycle.
